// File: rtl/counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared defaults, types and the round-robin index helper for
//                the shared-incrementer counter block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int CNT_NUM_CH = 4;
  localparam int CNT_WIDTH  = 32;
  localparam int CNT_PEND_W = 4;
  localparam int SEL_W      = $clog2(CNT_NUM_CH);

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [CNT_PEND_W-1:0] pend_t;

  // Channel reached by stepping 'step' positions past 'base' around a ring of n.
  function automatic int rr_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_shared_rr_sched_arbiter.sv
// ============================================================================
//  Module      : counter_rr_arbiter
//  Description : Round-robin arbiter; search begins one past the pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_rr_arbiter
  import counter_pkg::*;
#(
  parameter int NUM_CH = CNT_NUM_CH
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx,
  output logic                      gnt_vld
);

  localparam int c_sel_w = $clog2(NUM_CH);

  logic [c_sel_w-1:0] w_cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = c_sel_w'(rr_index(int'(ptr), k, NUM_CH));
      if (!gnt_vld && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        gnt_idx       = w_cand;
        gnt_vld       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_shared_rr_sched.sv
// ============================================================================
//  Module      : counter_shared_rr_sched
//  Description : NUM_CH event counters sharing one incrementer under
//                round-robin scheduling. Optional COUNTER_SHARED_BATCH_EN
//                makes a grant retire the whole pending value at once.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_shared_rr_sched
  import counter_pkg::*;
#(
  parameter int NUM_CH = CNT_NUM_CH,
  parameter int WIDTH  = CNT_WIDTH,
  parameter int PEND_W = CNT_PEND_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         inc_req,
  input  logic [NUM_CH-1:0]         clr_ch,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  output logic [WIDTH-1:0]          rd_count,
  output logic [NUM_CH-1:0]         grant,
  output logic [NUM_CH-1:0]         wrap_flag,
  output logic [NUM_CH-1:0]         ovf_flag
);

  localparam int                c_sel_w    = $clog2(NUM_CH);
  localparam logic [PEND_W-1:0] c_pend_max = {PEND_W{1'b1}};

  logic [WIDTH-1:0]   r_count [NUM_CH];
  logic [PEND_W-1:0]  r_pend  [NUM_CH];
  logic [NUM_CH-1:0]  r_wrap;
  logic [NUM_CH-1:0]  r_ovf;
  logic [c_sel_w-1:0] r_ptr;

  logic [NUM_CH-1:0]  w_req;
  logic [NUM_CH-1:0]  w_grant;
  logic [c_sel_w-1:0] w_gnt_idx;
  logic               w_gnt_vld;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;

  // A channel being cleared this cycle must not compete for the adder.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_req
      assign w_req[i] = (r_pend[i] != '0) && !clr_ch[i];
    end
  endgenerate

  counter_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  // The single shared incrementer, fed by the granted channel's entry.
  always_comb begin
    w_addend = '0;
`ifdef COUNTER_SHARED_BATCH_EN
    w_addend = WIDTH'(r_pend[w_gnt_idx]);
`else
    w_addend = WIDTH'(1);
`endif
    {w_carry, w_sum} = {1'b0, r_count[w_gnt_idx]} + {1'b0, w_addend};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
        r_pend[i]  <= '0;
      end
      r_wrap <= '0;
      r_ovf  <= '0;
      r_ptr  <= c_sel_w'(NUM_CH - 1);
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= w_gnt_idx;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_ch[i]) begin
          r_count[i] <= '0;
          r_pend[i]  <= '0;
          r_wrap[i]  <= 1'b0;
          r_ovf[i]   <= 1'b0;
        end else begin
          if (w_grant[i]) begin
            r_count[i] <= w_sum;
            if (w_carry) begin
              r_wrap[i] <= 1'b1;
            end
          end
`ifdef COUNTER_SHARED_BATCH_EN
          if (w_grant[i]) begin
            r_pend[i] <= inc_req[i] ? PEND_W'(1) : '0;
          end else if (inc_req[i]) begin
            if (r_pend[i] == c_pend_max) begin
              r_ovf[i] <= 1'b1;
            end else begin
              r_pend[i] <= r_pend[i] + PEND_W'(1);
            end
          end
`else
          case ({inc_req[i], w_grant[i]})
            2'b10: begin
              if (r_pend[i] == c_pend_max) begin
                r_ovf[i] <= 1'b1;
              end else begin
                r_pend[i] <= r_pend[i] + PEND_W'(1);
              end
            end
            2'b01:   r_pend[i] <= r_pend[i] - PEND_W'(1);
            default: r_pend[i] <= r_pend[i];
          endcase
`endif
        end
      end
    end
  end

  assign rd_count  = (int'(rd_sel) < NUM_CH) ? r_count[rd_sel] : '0;
  assign grant     = w_grant;
  assign wrap_flag = r_wrap;
  assign ovf_flag  = r_ovf;

endmodule

`default_nettype wire
